// File: rtl/data_sync.sv
// data_sync: multi-flop enable synchronizer that captures a held source bus on the synced enable's rising edge
module data_sync #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
   input  logic                 BUS_ENABLE,
   input  logic                 CLR_ERR,
   output logic [BUS_WIDTH-1:0] SYNC_BUS,
   output logic                 ENABLE_PULSE,
   output logic                 STAB_ERR
);
   if (NUM_STAGES < 2 || BUS_WIDTH < 1) begin : g_param_err
      $error("data_sync: NUM_STAGES must be >= 2 and BUS_WIDTH >= 1");
   end
   logic [NUM_STAGES-1:0] r_sync;
   logic                  r_en_d;
   logic                  r_chk;
   logic                  w_sync_en;
   logic                  w_rise;
   logic                  w_err_set;
   assign w_sync_en = r_sync[NUM_STAGES-1];
   assign w_rise    = w_sync_en & ~r_en_d;
   // one cycle after capture the bus must still match what was taken
   assign w_err_set = r_chk & w_sync_en & (UNSYNC_BUS != SYNC_BUS);
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync       <= '0;
         r_en_d       <= 1'b0;
         r_chk        <= 1'b0;
         SYNC_BUS     <= '0;
         ENABLE_PULSE <= 1'b0;
         STAB_ERR     <= 1'b0;
      end else begin
         r_sync       <= {r_sync[NUM_STAGES-2:0], BUS_ENABLE};
         r_en_d       <= w_sync_en;
         r_chk        <= w_rise;
         ENABLE_PULSE <= w_rise;
         SYNC_BUS     <= w_rise ? UNSYNC_BUS : SYNC_BUS;
         STAB_ERR     <= w_err_set | (STAB_ERR & ~CLR_ERR);
      end
   end
endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: scoreboard bench for data_sync at depth 2 / width 8 and depth 4 / width 16
module tb_data_sync;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  a_bus;
   logic        a_en, a_clr;
   logic [7:0]  a_sync;
   logic        a_pulse, a_err;
   logic [15:0] b_bus;
   logic        b_en, b_clr;
   logic [15:0] b_sync;
   logic        b_pulse, b_err;
   logic [7:0]  q_a[$];
   logic [15:0] q_b[$];
   logic [7:0]  exp_a, rnd;
   logic [15:0] exp_b;
   logic        prev_a = 1'b0, prev_b = 1'b0;
   int          n_checks = 0, n_errors = 0;
   int          pulses_a = 0, pulses_b = 0, pushes_a = 0, pushes_b = 0;

   always #5 clk = ~clk;

   data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) u_a (
      .CLK(clk), .RST(rst_n), .UNSYNC_BUS(a_bus), .BUS_ENABLE(a_en), .CLR_ERR(a_clr),
      .SYNC_BUS(a_sync), .ENABLE_PULSE(a_pulse), .STAB_ERR(a_err));

   data_sync #(.NUM_STAGES(4), .BUS_WIDTH(16)) u_b (
      .CLK(clk), .RST(rst_n), .UNSYNC_BUS(b_bus), .BUS_ENABLE(b_en), .CLR_ERR(b_clr),
      .SYNC_BUS(b_sync), .ENABLE_PULSE(b_pulse), .STAB_ERR(b_err));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] d);
      a_bus = d;
      a_en  = 1'b1;
      q_a.push_back(d);
      pushes_a++;
   endtask

   // every pulse must have a pending expectation and last exactly one cycle
   always @(negedge clk) begin
      if (rst_n && a_pulse) begin
         pulses_a++;
         check("a_pulse_expected", q_a.size() != 0, 1);
         if (q_a.size() != 0) begin
            exp_a = q_a.pop_front();
            check("a_sync_data", a_sync, exp_a);
         end
         check("a_pulse_width", prev_a, 0);
      end
      if (rst_n && b_pulse) begin
         pulses_b++;
         check("b_pulse_expected", q_b.size() != 0, 1);
         if (q_b.size() != 0) begin
            exp_b = q_b.pop_front();
            check("b_sync_data", b_sync, exp_b);
         end
         check("b_pulse_width", prev_b, 0);
      end
      prev_a = a_pulse;
      prev_b = b_pulse;
   end

   initial begin
      rst_n = 1'b0;
      a_bus = '0; a_en = 1'b0; a_clr = 1'b0;
      b_bus = '0; b_en = 1'b0; b_clr = 1'b0;
      step(5);
      check("rst_a_sync", a_sync, 0);
      check("rst_a_pulse", a_pulse, 0);
      check("rst_a_err", a_err, 0);
      check("rst_b_sync", b_sync, 0);
      check("rst_b_pulse", b_pulse, 0);
      rst_n = 1'b1;
      step(2);
      // basic transfer, pulse after E3
      push_a(8'hA5);
      step(2);
      check("t1_pulse_e2", a_pulse, 0);
      step(1);
      check("t1_pulse_e3", a_pulse, 1);
      check("t1_sync_e3", a_sync, 8'hA5);
      step(1);
      check("t1_pulse_e4", a_pulse, 0);
      check("t1_err_e4", a_err, 0);
      a_en = 1'b0;
      step(4);
      // two back-to-back transfers, bus changes while enable is low
      foreach (q_a[i]) check("t2_queue_empty", 1, 0);
      for (int i = 0; i < 2; i++) begin
         push_a(i == 0 ? 8'h3C : 8'hC3);
         step(4);
         check("t2_sync_high", a_sync, i == 0 ? 8'h3C : 8'hC3);
         a_en  = 1'b0;
         a_bus = 8'h00;
         step(4);
         check("t2_sync_after_fall", a_sync, i == 0 ? 8'h3C : 8'hC3);
         check("t2_err", a_err, 0);
      end
      check("t2_pulse_count", pulses_a, 3);
      // bus changes inside the hold window
      push_a(8'h11);
      step(3);
      check("t3_pulse", a_pulse, 1);
      a_bus = 8'h22;
      step(1);
      check("t3_err_set", a_err, 1);
      check("t3_sync_kept", a_sync, 8'h11);
      step(10);
      check("t3_err_sticky", a_err, 1);
      a_clr = 1'b1;
      step(1);
      a_clr = 1'b0;
      check("t3_err_cleared", a_err, 0);
      a_en = 1'b0;
      step(4);
      // reset at E2 of a transfer, enable still high at release
      a_bus = 8'h77;
      a_en  = 1'b1;
      step(2);
      rst_n = 1'b0;
      #1;
      check("t4_rst_pulse", a_pulse, 0);
      check("t4_rst_sync", a_sync, 0);
      step(2);
      check("t4_no_pulse", a_pulse, 0);
      rst_n = 1'b1;
      q_a.push_back(8'h77);
      pushes_a++;
      step(2);
      check("t4_pulse_r2", a_pulse, 0);
      step(1);
      check("t4_pulse_r3", a_pulse, 1);
      check("t4_sync", a_sync, 8'h77);
      a_en = 1'b0;
      step(4);
      // set and clear on the same edge: set wins
      push_a(8'h55);
      step(3);
      a_bus = 8'h66;
      a_clr = 1'b1;
      step(1);
      a_clr = 1'b0;
      check("t6_set_wins", a_err, 1);
      a_clr = 1'b1;
      step(1);
      a_clr = 1'b0;
      check("t6_cleared", a_err, 0);
      a_en = 1'b0;
      step(4);
      // deeper, wider instance
      b_bus = 16'hBEEF;
      b_en  = 1'b1;
      q_b.push_back(16'hBEEF);
      pushes_b++;
      step(4);
      check("t5_pulse_e4", b_pulse, 0);
      step(1);
      check("t5_pulse_e5", b_pulse, 1);
      check("t5_sync", b_sync, 16'hBEEF);
      step(1);
      check("t5_pulse_e6", b_pulse, 0);
      check("t5_err", b_err, 0);
      b_en = 1'b0;
      step(6);
      // random transfers on both instances
      for (int i = 0; i < 6; i++) begin
         rnd = 8'($urandom);
         push_a(rnd);
         b_bus = 16'($urandom);
         b_en  = 1'b1;
         q_b.push_back(b_bus);
         pushes_b++;
         step(6);
         a_en = 1'b0;
         b_en = 1'b0;
         step(6);
         check("rand_a_err", a_err, 0);
         check("rand_b_err", b_err, 0);
      end
      step(2);
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      check("a_pulse_total", pulses_a, pushes_a);
      check("b_pulse_total", pulses_b, pushes_b);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
